// File: rtl/multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer
//
// Control and operand stage that sits in front of the iterative multiplier and
// divider. A one-cycle ctrl_MULT / ctrl_DIV pulse starts an operation. The
// operands are captured on that edge and held on the operand outputs until the
// next start. A shared iteration counter runs while the operation is in
// flight. When the selected datapath reaches its final iteration, its result
// and exception are captured, and data_resultRDY pulses for one cycle.
//
// Ports
//   clock, reset_n                 rising-edge clock, async active-low reset
//   ctrl_MULT, ctrl_DIV            start pulses (MULT wins if both are high)
//   data_operandA/B   [WIDTH]      operands, valid only in the start cycle
//   operandA_out/B    [WIDTH]      operands to the datapaths (live in start cycle)
//   mult_start, div_start          combinational start/load pulses to datapaths
//   count             [6]          shared iteration counter
//   mult_result/exception          multiplier outputs
//   div_result/exception           divider outputs (exception = divide by zero)
//   data_result/exception          captured result, held until next completion
//   data_resultRDY                 one-cycle completion pulse
//   busy                           high while MULT or DIV is in flight
// -----------------------------------------------------------------------------
module multdiv_sequencer #(
  parameter int WIDTH       = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int MULT_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] operandA_out,
  output logic [WIDTH-1:0] operandB_out,
  output logic             mult_start,
  output logic             div_start,
  output logic [5:0]       count,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_exception,
  input  logic [WIDTH-1:0] div_result,
  input  logic             div_exception,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       count_q, count_d;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic start_mult, start_div, start_any;

  // A simultaneous DIV request is dropped in favour of MULT.
  assign start_mult = ctrl_MULT;
  assign start_div  = ctrl_DIV & ~ctrl_MULT;
  assign start_any  = ctrl_MULT | ctrl_DIV;

  assign mult_start = start_mult;
  assign div_start  = start_div;

  // The datapaths load on the start edge, so they must see the live operands in
  // that cycle; afterwards the held copies keep them stable.
  assign operandA_out = start_any ? data_operandA : opa_q;
  assign operandB_out = start_any ? data_operandB : opb_q;

  assign count          = count_q;
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == S_MULT) || (state_q == S_DIV);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    // A start in any state (including mid-operation) restarts from count 0;
    // an in-flight operation is abandoned without a completion pulse.
    if (start_mult) begin
      state_d = S_MULT;
      count_d = '0;
    end else if (start_div) begin
      state_d = S_DIV;
      count_d = '0;
    end else begin
      unique case (state_q)
        S_MULT: begin
          if (count_q == MULT_N) begin
            state_d  = S_DONE;
            result_d = mult_result;
            exc_d    = mult_exception;
            rdy_d    = 1'b1;
          end else begin
            count_d = count_q + 6'd1;
          end
        end
        S_DIV: begin
          if (count_q == DIV_N) begin
            state_d  = S_DONE;
            // On divide-by-zero the quotient is meaningless; report zero.
            result_d = div_exception ? '0 : div_result;
            exc_d    = div_exception;
            rdy_d    = 1'b1;
          end else begin
            count_d = count_q + 6'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          count_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      if (start_any) begin
        opa_q <= data_operandA;
        opb_q <= data_operandB;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multdiv_sequencer
//
// Drives the sequencer with directed and randomized start pulses. A behavioural
// multiplier/divider sits on the datapath side and presents a valid result only
// on its final iteration. A transaction-level model tracks the in-flight
// operation by its age in cycles and predicts busy, count, the completion pulse
// and the captured result.
// -----------------------------------------------------------------------------
module tb_multdiv_sequencer;

  localparam int W      = 32;
  localparam int N_MULT = 16;
  localparam int N_DIV  = 32;

  logic          clock;
  logic          reset_n;
  logic          ctrl_mult, ctrl_div;
  logic [W-1:0]  op_a, op_b;
  logic [W-1:0]  opa_out, opb_out;
  logic          m_start, d_start;
  logic [5:0]    cnt;
  logic [W-1:0]  mres, dres;
  logic          mexc, dexc;
  logic [W-1:0]  res_out;
  logic          exc_out, rdy, busy;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_sequencer #(
    .WIDTH      (W),
    .DIV_CYCLES (N_DIV),
    .MULT_CYCLES(N_MULT)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_mult),
    .ctrl_DIV       (ctrl_div),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .operandA_out   (opa_out),
    .operandB_out   (opb_out),
    .mult_start     (m_start),
    .div_start      (d_start),
    .count          (cnt),
    .mult_result    (mres),
    .mult_exception (mexc),
    .div_result     (dres),
    .div_exception  (dexc),
    .data_result    (res_out),
    .data_exception (exc_out),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural datapaths: a result is valid only when the counter hits the
  // final iteration; otherwise they present junk, and their exception flags are
  // set, so a capture at the wrong time or from the wrong unit shows up.
  longint mp;
  always_comb begin
    mp = longint'($signed(opa_out)) * longint'($signed(opb_out));
    if (cnt == 6'(N_MULT)) begin
      mres = mp[31:0];
      mexc = (mp != longint'(int'(mp)));
    end else begin
      mres = 32'hDEAD_0000 | 32'(cnt);
      mexc = 1'b1;
    end
    if (cnt == 6'(N_DIV)) begin
      if (opb_out == '0) begin
        dres = 32'h1234_5678;
        dexc = 1'b1;
      end else begin
        dres = 32'($signed(opa_out) / $signed(opb_out));
        dexc = 1'b0;
      end
    end else begin
      dres = 32'hBAD0_0000 | 32'(cnt);
      dexc = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference state.
  bit          pend;      // operation in flight
  int          age;       // edges since its start edge
  int          tgt;       // iteration count of the operation
  logic [31:0] exp_res;
  bit          exp_exc;
  logic [31:0] last_res;
  bit          last_exc;
  logic [31:0] hold_a, hold_b;
  bit          rdy_exp;

  task automatic model_reset();
    pend = 0; age = 0; tgt = 0; rdy_exp = 0;
    last_res = '0; last_exc = 0; hold_a = '0; hold_b = '0;
  endtask

  // One clock cycle: called at a falling edge, drives the inputs, lets one
  // rising edge happen, then checks everything at the next falling edge.
  task automatic step(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    longint lp;
    ctrl_mult = m; ctrl_div = d; op_a = a; op_b = b;
    #1;
    check("mult_start", 32'(m_start), 32'(m));
    check("div_start", 32'(d_start), 32'(d & ~m));
    if (m | d) begin
      check("opA_live", opa_out, a);
      check("opB_live", opb_out, b);
    end
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0; ctrl_div = 1'b0; op_a = $urandom; op_b = $urandom;
    rdy_exp = 0;
    if (m | d) begin
      pend = 1; age = 0; hold_a = a; hold_b = b;
      if (m) begin
        tgt = N_MULT;
        lp = longint'($signed(a)) * longint'($signed(b));
        exp_res = lp[31:0];
        exp_exc = (lp != longint'(int'(lp)));
      end else begin
        tgt = N_DIV;
        if (b == '0) begin
          exp_res = '0; exp_exc = 1;
        end else begin
          exp_res = 32'($signed(a) / $signed(b)); exp_exc = 0;
        end
      end
    end else if (pend) begin
      age++;
      if (age == tgt + 1) begin
        pend = 0; rdy_exp = 1; last_res = exp_res; last_exc = exp_exc;
      end
    end
    @(negedge clock);
    check("rdy", 32'(rdy), 32'(rdy_exp));
    check("busy", 32'(busy), 32'(pend));
    if (pend) check("count", 32'(cnt), 32'(age));
    else if (!rdy_exp) check("count_idle", 32'(cnt), 32'd0);
    check("data_result", res_out, last_res);
    check("data_exc", 32'(exc_out), 32'(last_exc));
    check("holdA", opa_out, hold_a);
    check("holdB", opb_out, hold_b);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  // Runs idle cycles until the model expects completion; bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0, $urandom, $urandom);
      n++;
    end while (!rdy_exp && n < 100);
  endtask

  int lat;

  initial begin
    model_reset();
    reset_n = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0; op_a = '0; op_b = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_count", 32'(cnt), 32'd0);
    check("rst_result", res_out, 32'd0);
    check("rst_opA", opa_out, 32'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    run_idle(3);

    // 1: DIV 100 / -7
    step(1'b0, 1'b1, 32'd100, -32'sd7);
    wait_done(lat);
    check("t1_latency", 32'(lat), 32'd33);
    check("t1_result", res_out, 32'hFFFF_FFF2);
    check("t1_exc", 32'(exc_out), 32'd0);

    // 2: DIV 5 / 0
    step(1'b0, 1'b1, 32'd5, 32'd0);
    wait_done(lat);
    check("t2_latency", 32'(lat), 32'd33);
    check("t2_result", res_out, 32'd0);
    check("t2_exc", 32'(exc_out), 32'd1);
    check("t2_holdB", opb_out, 32'd0);
    run_idle(2);

    // 3: MULT 6 * -7
    step(1'b1, 1'b0, 32'd6, -32'sd7);
    wait_done(lat);
    check("t3_latency", 32'(lat), 32'd17);
    check("t3_result", res_out, 32'hFFFF_FFD6);
    check("t3_exc", 32'(exc_out), 32'd0);
    run_idle(1);

    // 4: DIV 100/7 aborted at count 10 by MULT 3*4
    step(1'b0, 1'b1, 32'd100, 32'd7);
    run_idle(10);
    check("t4_count10", 32'(cnt), 32'd10);
    step(1'b1, 1'b0, 32'd3, 32'd4);
    wait_done(lat);
    check("t4_latency", 32'(lat), 32'd17);
    check("t4_result", res_out, 32'd12);
    run_idle(1);

    // 5: both starts together, MULT wins
    step(1'b1, 1'b1, 32'd9, 32'd3);
    wait_done(lat);
    check("t5_latency", 32'(lat), 32'd17);
    check("t5_result", res_out, 32'd27);

    // 6: async reset at count 20 of a divide
    run_idle(2);
    step(1'b0, 1'b1, 32'd1000, 32'd3);
    run_idle(20);
    check("t6_count20", 32'(cnt), 32'd20);
    #2 reset_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_count", 32'(cnt), 32'd0);
    check("t6_result", res_out, 32'd0);
    check("t6_exc", 32'(exc_out), 32'd0);
    check("t6_rdy", 32'(rdy), 32'd0);
    check("t6_opA", opa_out, 32'd0);
    check("t6_opB", opb_out, 32'd0);
    model_reset();
    @(posedge clock); @(negedge clock);
    reset_n = 1'b1;
    run_idle(40);

    // Randomized operations with aborts, DONE-cycle restarts and idle gaps.
    for (int i = 0; i < 40; i++) begin
      int kind, n, gap;
      logic [31:0] a, b;
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
      b = 32'($urandom_range(0, 200)) - 32'd100;
      if (b == 32'hFFFF_FFFF) b = '0;
      step(kind != 1, kind != 0, a, b);
      n = (kind == 1) ? N_DIV : N_MULT;
      case ($urandom_range(0, 2))
        0:       gap = n + 1;
        1:       gap = $urandom_range(0, n);
        default: gap = n + 5;
      endcase
      run_idle(gap);
    end
    run_idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
